// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// One operation in flight. An accept in IDLE either finishes straight
// away or starts a 32-iteration CALC phase:
//   - divide by zero and signed DIV/REM overflow go IDLE -> DONE,
//   - multiplies use radix-2 shift-add into a 64-bit accumulator,
//   - divides use radix-2 restoring division.
// The operands are converted to magnitudes at accept. The sign is applied
// on entry to DONE.
//
// Optional macro: FAST_MUL_EN. When it is defined, every multiply finishes
// in one cycle on a 33x33 signed array multiplier, and the iterative
// multiply datapath is removed. Divides are unchanged.
//
// Ports:
//   clk_i, rst_i     clock and synchronous active-high reset
//   en_i             operation request (sampled only in IDLE)
//   funct3_i         RV32M op select
//   rs1_data_i       operand A (multiplicand / dividend)
//   rs2_data_i       operand B (multiplier / divisor)
//   rd_i             destination register tag
//   kill_i           abort the in-flight op
//   busy_o           unit occupied, stall upstream
//   valid_o          one-cycle result strobe
//   result_o, rd_o   result and tag (hold after valid_o)
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opd_q, opd_d;      // addend (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;      // mul: {hi, lo/multiplier}; div: {rem, quo}
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   res_q, res_d;

  function automatic logic [XLEN-1:0] sel_res(input logic [2:0] f3,
                                              input logic [2*XLEN-1:0] prod,
                                              input logic [XLEN-1:0] quo,
                                              input logic [XLEN-1:0] rem);
    case (f3)
      3'b000:                 sel_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel_res = quo;
      default:                sel_res = rem;
    endcase
  endfunction

  // ---------------- accept-side decode ----------------
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign is_div   = funct3_i[2];
  assign sgn_a    = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sgn_b    = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                    (funct3_i == 3'b110);
  assign a_neg    = sgn_a & rs1_data_i[XLEN-1];
  assign b_neg    = sgn_b & rs2_data_i[XLEN-1];
  assign a_mag    = a_neg ? ('0 - rs1_data_i) : rs1_data_i;
  assign b_mag    = b_neg ? ('0 - rs2_data_i) : rs2_data_i;
  assign div_zero = is_div && (rs2_data_i == '0);
  assign div_ovf  = is_div && !funct3_i[0] && (rs1_data_i == MIN_NEG) &&
                    (rs2_data_i == '1);
  // funct3[1] separates REM(U) from DIV(U).
  assign spec_res = div_zero ? (funct3_i[1] ? rs1_data_i : '1)
                             : (funct3_i[1] ? '0 : MIN_NEG);

`ifdef FAST_MUL_EN
  logic signed [2*XLEN+1:0] fa, fb, fprod;
  assign fa    = {{(XLEN+2){a_neg}}, rs1_data_i};
  assign fb    = {{(XLEN+2){b_neg}}, rs2_data_i};
  assign fprod = fa * fb;
`endif

  // ---------------- iteration datapath ----------------
  // Restoring divide: shift {rem,quo} left one bit, trial-subtract the divisor.
  logic [XLEN:0]     dsh;
  logic [XLEN+1:0]   ddiff;
  logic              dge;
  logic [2*XLEN-1:0] div_nxt, step_nxt;

  assign dsh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ddiff   = {1'b0, dsh} - {2'b00, opd_q};
  assign dge     = ~ddiff[XLEN+1];
  assign div_nxt = {dge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0], acc_q[XLEN-2:0], dge};

`ifdef FAST_MUL_EN
  assign step_nxt = div_nxt;
`else
  // Shift-add: conditionally add into the high half, then shift the
  // 65-bit {carry, acc} right so the multiplier bits drain out the bottom.
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_nxt;
  assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_nxt  = {msum, acc_q[XLEN-1:1]};
  assign step_nxt = op_q[2] ? div_nxt : mul_nxt;
`endif

  // On the exit iteration, the sign fix-up is applied to the final value.
  logic [2*XLEN-1:0] fix_prod;
  logic [XLEN-1:0]   fix_quo, fix_rem, fix_res;
  assign fix_prod = neg_res_q ? ('0 - step_nxt) : step_nxt;
  assign fix_quo  = neg_res_q ? ('0 - step_nxt[XLEN-1:0]) : step_nxt[XLEN-1:0];
  assign fix_rem  = neg_rem_q ? ('0 - step_nxt[2*XLEN-1:XLEN])
                              : step_nxt[2*XLEN-1:XLEN];
  assign fix_res  = sel_res(op_q, fix_prod, fix_quo, fix_rem);

  logic unused_bits;
  assign unused_bits = ^{ddiff[XLEN]};

  // ---------------- next state ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: begin
        if (!kill_i && en_i) begin
          rd_d = rd_i;
          op_d = funct3_i;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            res_d    = spec_res;
            rd_out_d = rd_i;
`ifdef FAST_MUL_EN
          end else if (!is_div) begin
            state_d  = S_DONE;
            res_d    = sel_res(funct3_i, fprod[2*XLEN-1:0], '0, '0);
            rd_out_d = rd_i;
`endif
          end else begin
            state_d   = S_CALC;
            cnt_d     = CNT_W'(XLEN-1);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            opd_d     = is_div ? b_mag : a_mag;
            acc_d     = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_nxt;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            res_d    = fix_res;
            rd_out_d = rd_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      res_q     <= res_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = res_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, tags, kill and reset.
module tb_muldiv_unit;

`ifdef FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, en, kill;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .funct3_i(f3),
    .rs1_data_i(a), .rs2_data_i(b), .rd_i(rd), .kill_i(kill),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one op; measure the cycle of valid_o relative to the accept edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r,
                        input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk); en = 1'b1; f3 = op; a = x; b = y; rd = r;
    @(negedge clk); en = 1'b0; n = 1;
    chk({tag, ".busy"}, 32'(busy_o), 32'd1);
    while (!valid_o && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, result_o, exp);
    chk({tag, ".rd"}, 32'(rd_o), 32'(r));
    @(negedge clk);
    chk({tag, ".idle"}, 32'({busy_o, valid_o}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    rst = 1'b1; en = 1'b0; kill = 1'b0; f3 = '0; a = '0; b = '0; rd = '0;
    repeat (2) @(negedge clk);
    chk("rst.out", {busy_o, valid_o, rd_o, result_o[24:0]}, 32'd0);
    chk("rst.res", result_o, 32'd0);
    rst = 1'b0;

    run_op("mul",     3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       ML);
    run_op("mulh",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, ML);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, ML);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, ML);
    run_op("mulhu2",  3'b011, 32'h80000000, 32'd4,        5'd9,  32'd2,        ML);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
    run_op("divnb",   3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33);
    run_op("remnb",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        33);
    run_op("divu1",   3'b101, 32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, 33);
    run_op("div0",    3'b100, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
    run_op("remu0",   3'b111, 32'd5,        32'd0,        5'd16, 32'd5,        1);
    run_op("divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
    run_op("removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1);
    run_op("divu",    3'b101, 32'd100,      32'd7,        5'd19, 32'd14,       33);
    run_op("remu",    3'b111, 32'd100,      32'd7,        5'd20, 32'd2,        33);

    // Kill a DIVU at T+10, with a stray en pulse during CALC.
    @(negedge clk); en = 1'b1; f3 = 3'b101; a = 32'd100; b = 32'd7; rd = 5'd21;
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd3; rd = 5'd22;
    @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("kill.busy", 32'(busy_o), 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("kill.novalid", 32'(nv), 32'd0);
    chk("kill.res", result_o, 32'd2);
    run_op("mul3", 3'b000, 32'd3, 32'd3, 5'd1, 32'd9, ML);

    // kill wins over en in IDLE.
    @(negedge clk); en = 1'b1; kill = 1'b1; f3 = 3'b000; a = 32'd2; b = 32'd2; rd = 5'd2;
    @(negedge clk); en = 1'b0; kill = 1'b0;
    chk("killidle.busy", 32'(busy_o), 32'd0);
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("killidle.novalid", 32'(nv), 32'd0);

    // Reset at T+20 of a DIV.
    @(negedge clk); en = 1'b1; f3 = 3'b100; a = 32'hFFFFFFF9; b = 32'd2; rd = 5'd3;
    @(negedge clk); en = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.ctl", 32'({busy_o, valid_o, rd_o}), 32'd0);
    chk("rstmid.res", result_o, 32'd0);
    rst = 1'b0;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    chk("rstmid.novalid", 32'(nv), 32'd0);
    run_op("remu94", 3'b111, 32'd9, 32'd4, 5'd4, 32'd1, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the instruction decoder.
- Accepts one operation when the decoder asserts its mul/div enable on an R-type instruction with funct7 = MULDIV.
- Stalls the pipeline while computing; returns a tagged 32-bit result that is written back through the SRC_MUL register-source path.
- One operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  operation request; driven by the decoder's muldiv_en_o.
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  in  XLEN  operand A (multiplicand / dividend).
- rs2_data_i  in  XLEN  operand B (multiplier / divisor).
- rd_i  in  5  destination register tag.
- kill_i  in  1  abort the in-flight op (pipeline flush).
- busy_o  out  1  unit occupied; pipeline must stall.
- valid_o  out  1  result_o/rd_o valid this cycle (one-cycle pulse).
- result_o  out  XLEN  operation result.
- rd_o  out  5  destination tag captured at accept.

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is synchronous, active-high on rst_i. Reset forces state IDLE; busy_o=0, valid_o=0, result_o=0, rd_o=0, counter=0. Reset mid-operation discards the op; no valid_o follows.
- States:
  - IDLE, CALC, DONE.
  - busy_o = (state != IDLE), registered-state decode.
  - valid_o = (state == DONE).
- Accept: en_i=1 in IDLE at edge T; funct3, operands and rd are latched. en_i is ignored in CALC and DONE; upstream holds the instruction while busy_o=1.
- IDLE -> DONE directly (special cases, valid_o at T+1):
  - Divide by zero (B=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
  - Signed overflow, DIV/REM with A=0x80000000 and B=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- IDLE -> CALC otherwise:
  - Counter loads XLEN-1.
  - Operands are converted to magnitudes per signedness: MULH signed/signed, MULHSU A signed/B unsigned, MULHU and MUL/DIVU/REMU unsigned; DIV/REM signed.
  - Result-sign flags are recorded.
- CALC: one iteration per cycle, counter decrements, exit to DONE after the counter=0 iteration. Normal ops: valid_o at T+33.
  - Multiply: radix-2 shift-add into a 64-bit accumulator. No early termination.
  - Divide: radix-2 restoring, 32-bit quotient and 32-bit remainder.
- CALC -> DONE: sign fix-up is applied on entry.
  - Product is negated if the operand signs differ (signed ops).
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - result_o selection: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV(U) = quotient; REM(U) = remainder.
- DONE: result_o and rd_o are driven, valid_o=1 for exactly one cycle, then the unit returns to IDLE. result_o/rd_o hold their last values afterwards.
- Back-to-back: a new en_i is only sampled in IDLE, so the earliest next accept is the cycle after DONE.
- kill_i:
  - In CALC or DONE: next state IDLE, valid_o suppressed (0 in the following cycle), result_o not updated.
  - In IDLE: kill_i has priority over en_i; no accept.
  - kill_i with rst_i: reset wins (same effect).

Optional Feature:
- FAST_MUL_EN defined:
  - All four multiply ops go IDLE -> DONE using a single 33x33 signed array multiply, so valid_o is asserted at T+1.
  - The multiply datapath inside CALC is removed.
  - Divides are unchanged.
- FAST_MUL_EN undefined: multiplies use the iterative 32-cycle path (valid_o at T+33).

Test Plan:
- MUL 7 x 6, rd=5: accept at T; busy_o=1 from T+1; valid_o only at T+33 (T+1 with FAST_MUL_EN); result_o=42, rd_o=5; busy_o=0 at T+34.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. Each at T+33.
- DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both at T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM with same operands -> 0.
- Start DIVU; assert kill_i at T+10 -> IDLE at T+11, no valid_o pulse. en_i pulses during CALC are ignored. A new MUL 3 x 3 accepted right after returns 9.
- rst_i at T+20 of a DIV -> all outputs 0 at T+21, no valid_o; a subsequent REMU 9 / 4 returns 1.
